// File: rtl/fw_loader_if.sv
// Byte-stream and instruction-memory write bus for the firmware loader.
// master = the loader (consumes bytes, drives memory/CPU control); slave = source/memory side.
interface fw_loader_if #(
   parameter int CPU_WIDTH = 32
);
   logic                 byte_valid;
   logic [7:0]           byte_data;
   logic                 byte_ready;
   logic                 mem_we;
   logic [CPU_WIDTH-1:0] mem_address;
   logic [CPU_WIDTH-1:0] mem_data;
   logic                 cpu_reset_n;
   logic                 load_done;
   logic                 load_error;

   // Handshake: a byte moves only on a cycle where byte_valid && byte_ready;
   // the source must hold byte_data stable while byte_valid is high and byte_ready is low.
   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output mem_we,
      output mem_address,
      output mem_data,
      output cpu_reset_n,
      output load_done,
      output load_error
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  mem_we,
      input  mem_address,
      input  mem_data,
      input  cpu_reset_n,
      input  load_done,
      input  load_error
   );
endinterface

// File: rtl/fw_loader.sv
// Firmware loader: assembles a byte stream into instruction words, writes them to
// instruction memory and releases the CPU only after the image checksum matches.
module fw_loader #(
   parameter int          CPU_WIDTH     = 32,
   parameter int          FW_LENGTH     = 8,
   parameter logic [31:0] CMD_WIDTH     = 32'h4,
   parameter logic [31:0] START_ADDRESS = 32'h0
) (
   input  logic        clk,
   input  logic        s_reset,
   fw_loader_if.master io_bus,
   output logic [2:0]  o_dbg_state
);
   localparam int BYTES = CPU_WIDTH / 8;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int WW    = (FW_LENGTH > 1) ? $clog2(FW_LENGTH) : 1;

   localparam logic [7:0]           SYNC_BYTE  = 8'hA5;
   localparam logic [BW-1:0]        LAST_BYTE  = BW'(BYTES - 1);
   localparam logic [WW-1:0]        LAST_WORD  = WW'(FW_LENGTH - 1);
   localparam logic [CPU_WIDTH-1:0] ADDR_START = CPU_WIDTH'(START_ADDRESS);
   localparam logic [CPU_WIDTH-1:0] ADDR_STEP  = CPU_WIDTH'(CMD_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;

   logic [BW-1:0]        r_byte_idx;
   logic [WW-1:0]        r_word_idx;
   logic [CPU_WIDTH-1:0] r_shift;
   logic [7:0]           r_csum;
   logic [CPU_WIDTH-1:0] r_next_addr;

   logic                 r_mem_we;
   logic [CPU_WIDTH-1:0] r_mem_address;
   logic [CPU_WIDTH-1:0] r_mem_data;
   logic                 r_cpu_reset_n;
   logic                 r_load_done;
   logic                 r_load_error;

   logic                 w_ready;
   logic                 w_xfer;
   logic                 w_sync;
   logic                 w_word_end;
   logic                 w_last_word;
   logic                 w_start;
   logic                 w_shift_en;
   logic                 w_word_wr;
   logic [CPU_WIDTH-1:0] w_word;

   // New byte enters at the top so the first byte of a word ends up in bits [7:0].
   assign w_word      = CPU_WIDTH'({io_bus.byte_data, r_shift} >> 8);

   assign w_ready     = (r_state != ST_DONE);
   assign w_xfer      = io_bus.byte_valid && w_ready;
   assign w_sync      = (io_bus.byte_data == SYNC_BYTE);
   assign w_word_end  = (r_byte_idx == LAST_BYTE);
   assign w_last_word = (r_word_idx == LAST_WORD);

   always_ff @(posedge clk) begin
      if (s_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      w_shift_en = 1'b0;
      w_word_wr  = 1'b0;
      case (r_state)
         ST_IDLE, ST_ERROR: begin
            if (w_xfer && w_sync) begin
               w_state_nx = ST_LOAD;
               w_start    = 1'b1;
            end
         end
         ST_LOAD: begin
            if (w_xfer) begin
               w_shift_en = 1'b1;
               if (w_word_end) begin
                  w_word_wr = 1'b1;
                  if (w_last_word) begin
                     w_state_nx = ST_CHECK;
                  end
               end
            end
         end
         ST_CHECK: begin
            if (w_xfer) begin
               w_state_nx = (io_bus.byte_data == r_csum) ? ST_DONE : ST_ERROR;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_DONE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (s_reset) begin
         r_byte_idx    <= '0;
         r_word_idx    <= '0;
         r_shift       <= '0;
         r_csum        <= '0;
         r_next_addr   <= ADDR_START;
         r_mem_we      <= 1'b0;
         r_mem_address <= '0;
         r_mem_data    <= '0;
      end else begin
         r_mem_we <= w_word_wr;
         if (w_start) begin
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_shift     <= '0;
            r_csum      <= '0;
            r_next_addr <= ADDR_START;
         end
         if (w_shift_en) begin
            r_shift    <= w_word;
            r_csum     <= r_csum ^ io_bus.byte_data;
            r_byte_idx <= w_word_end ? '0 : (r_byte_idx + BW'(1));
         end
         // Address advances by accumulation, wrapping naturally at CPU_WIDTH bits.
         if (w_word_wr) begin
            r_mem_data    <= w_word;
            r_mem_address <= r_next_addr;
            r_next_addr   <= r_next_addr + ADDR_STEP;
            r_word_idx    <= r_word_idx + WW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s_reset) begin
         r_cpu_reset_n <= 1'b0;
         r_load_done   <= 1'b0;
         r_load_error  <= 1'b0;
      end else begin
         r_cpu_reset_n <= (w_state_nx == ST_DONE);
         r_load_done   <= (w_state_nx == ST_DONE);
         r_load_error  <= (w_state_nx == ST_ERROR);
      end
   end

   assign io_bus.byte_ready  = w_ready;
   assign io_bus.mem_we      = r_mem_we;
   assign io_bus.mem_address = r_mem_address;
   assign io_bus.mem_data    = r_mem_data;
   assign io_bus.cpu_reset_n = r_cpu_reset_n;
   assign io_bus.load_done   = r_load_done;
   assign io_bus.load_error  = r_load_error;
   assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_fw_loader.sv
// Bench for fw_loader: two instances (2-word image at 0x0, 8-word image at 0x100)
// fed directed and random byte streams, checked against a stream-parsing reference model.
module tb_fw_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   logic [2:0] dbg_a;
   logic [2:0] dbg_b;

   fw_loader_if #(.CPU_WIDTH(32)) if_a ();
   fw_loader_if #(.CPU_WIDTH(32)) if_b ();

   fw_loader #(
      .CPU_WIDTH(32), .FW_LENGTH(2), .CMD_WIDTH(32'h4), .START_ADDRESS(32'h0)
   ) dut_a (
      .clk(clk), .s_reset(rst_a), .io_bus(if_a.master), .o_dbg_state(dbg_a)
   );

   fw_loader #(
      .CPU_WIDTH(32), .FW_LENGTH(8), .CMD_WIDTH(32'h4), .START_ADDRESS(32'h100)
   ) dut_b (
      .clk(clk), .s_reset(rst_b), .io_bus(if_b.master), .o_dbg_state(dbg_b)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  stim_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] obs_a[$];
   logic [63:0] obs_b[$];
   bit          exp_done;
   bit          exp_err;

   // Every write strobe is logged as {address, data}.
   always @(negedge clk) begin
      if (if_a.mem_we === 1'b1) obs_a.push_back({if_a.mem_address, if_a.mem_data});
      if (if_b.mem_we === 1'b1) obs_b.push_back({if_b.mem_address, if_b.mem_data});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int obs_size(input int sel);
      return (sel == 0) ? obs_a.size() : obs_b.size();
   endfunction

   function automatic logic [63:0] get_obs(input int sel, input int k);
      if (sel == 0) return (k < obs_a.size()) ? obs_a[k] : 64'hx;
      return (k < obs_b.size()) ? obs_b[k] : 64'hx;
   endfunction

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? if_a.byte_ready : if_b.byte_ready;
   endfunction

   task automatic set_in(input int sel, input logic v, input logic [7:0] d);
      if (sel == 0) begin
         if_a.byte_valid = v;
         if_a.byte_data  = d;
      end else begin
         if_b.byte_valid = v;
         if_b.byte_data  = d;
      end
   endtask

   task automatic set_rst(input int sel, input logic v);
      if (sel == 0) rst_a = v;
      else rst_b = v;
   endtask

   // Reference model: walks the byte list with the loader's protocol rules and
   // produces the expected write list plus the final done/error status.
   task automatic model_run(input int fw_len, input logic [31:0] start);
      int         i;
      int         n;
      bit         stop;
      logic [7:0] cs;
      logic [31:0] word;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      i = 0;
      n = stim_q.size();
      stop = 0;
      while (i < n && !stop) begin
         if (stim_q[i] != 8'hA5) begin
            i++;
         end else begin
            i++;
            exp_err = 0;
            cs = 8'h00;
            for (int w = 0; w < fw_len && !stop; w++) begin
               if (i + 4 > n) begin
                  stop = 1;
               end else begin
                  word = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
                  cs = cs ^ stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
                  exp_q.push_back({start + 32'(w * 4), word});
                  i += 4;
               end
            end
            if (!stop && i < n) begin
               if (stim_q[i] == cs) begin
                  exp_done = 1;
                  stop = 1;
               end else begin
                  exp_err = 1;
               end
               i++;
            end else begin
               stop = 1;
            end
         end
      end
   endtask

   task automatic push_fixed(input logic [7:0] cs_byte);
      logic [7:0] img[9];
      img = '{8'hA5, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00};
      for (int k = 0; k < 9; k++) stim_q.push_back(img[k]);
      stim_q.push_back(cs_byte);
   endtask

   task automatic push_random(input int nwords, input bit good);
      logic [7:0] b;
      logic [7:0] cs;
      cs = 8'h00;
      stim_q.push_back(8'hA5);
      for (int k = 0; k < nwords * 4; k++) begin
         b = 8'($urandom);
         stim_q.push_back(b);
         cs = cs ^ b;
      end
      stim_q.push_back(good ? cs : (cs ^ 8'($urandom_range(1, 255))));
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
      int wait_n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         set_in(sel, 1'b0, 8'($urandom));
      end
      @(negedge clk);
      set_in(sel, 1'b1, b);
      wait_n = 0;
      while (get_ready(sel) !== 1'b1 && wait_n < 64) begin
         @(negedge clk);
         wait_n++;
      end
      if (wait_n >= 64) check("ready_timeout", {63'd0, get_ready(sel)}, 64'd1);
   endtask

   task automatic drive_stream(input int sel, input int max_gap);
      for (int k = 0; k < stim_q.size(); k++) begin
         send_byte(sel, stim_q[k], $urandom_range(0, max_gap));
      end
      @(negedge clk);
      set_in(sel, 1'b0, 8'($urandom));
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_dut(input int sel);
      @(negedge clk);
      set_in(sel, 1'b0, 8'h00);
      set_rst(sel, 1'b1);
      @(negedge clk);
      set_rst(sel, 1'b0);
      @(negedge clk);
   endtask

   task automatic check_writes(input int sel, input int base, input string tag);
      check({tag, "_nwrites"}, 64'(obs_size(sel) - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("%s_wr%0d", tag, k), get_obs(sel, base + k), exp_q[k]);
      end
   endtask

   task automatic check_status(input int sel, input string tag);
      logic done, err, crn, rdy;
      done = (sel == 0) ? if_a.load_done   : if_b.load_done;
      err  = (sel == 0) ? if_a.load_error  : if_b.load_error;
      crn  = (sel == 0) ? if_a.cpu_reset_n : if_b.cpu_reset_n;
      rdy  = (sel == 0) ? if_a.byte_ready  : if_b.byte_ready;
      check({tag, "_load_done"},   {63'd0, done}, {63'd0, exp_done});
      check({tag, "_load_error"},  {63'd0, err},  {63'd0, exp_err});
      check({tag, "_cpu_reset_n"}, {63'd0, crn},  {63'd0, exp_done});
      check({tag, "_byte_ready"},  {63'd0, rdy},  {63'd0, !exp_done});
   endtask

   initial begin
      int base;
      rst_a = 1'b1;
      rst_b = 1'b1;
      set_in(0, 1'b0, 8'h00);
      set_in(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_byte_ready",  {63'd0, if_a.byte_ready},  64'd1);
      check("rst_mem_we",      {63'd0, if_a.mem_we},      64'd0);
      check("rst_mem_address", {32'd0, if_a.mem_address}, 64'd0);
      check("rst_mem_data",    {32'd0, if_a.mem_data},    64'd0);
      check("rst_load_done",   {63'd0, if_a.load_done},   64'd0);
      check("rst_load_error",  {63'd0, if_a.load_error},  64'd0);
      check("rst_cpu_reset_n", {63'd0, if_a.cpu_reset_n}, 64'd0);
      check("rst_b_ready",     {63'd0, if_b.byte_ready},  64'd1);

      // Case 1: known two-word image, one byte per cycle
      stim_q.delete();
      push_fixed(8'h61);
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      check("c1_known_w0", get_obs(0, base),     {32'h0, 32'h00500093});
      check("c1_known_w1", get_obs(0, base + 1), {32'h4, 32'h00108133});
      check_writes(0, base, "c1");
      check_status(0, "c1");

      // DONE ignores valid bytes (byte_ready low)
      base = obs_size(0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         set_in(0, 1'b1, 8'hA5);
      end
      @(negedge clk);
      set_in(0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check("done_hold_nwrites", 64'(obs_size(0) - base), 64'd0);
      check("done_hold_load_done", {63'd0, if_a.load_done}, 64'd1);

      // Case 2: bad checksum, then full correct resend
      reset_dut(0);
      stim_q.delete();
      push_fixed(8'h62);
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      check_writes(0, base, "c2_bad");
      check_status(0, "c2_bad");
      check("c2_bad_err_set", {63'd0, if_a.load_error}, 64'd1);
      stim_q.delete();
      push_fixed(8'h61);
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      check_writes(0, base, "c2_resend");
      check_status(0, "c2_resend");

      // Case 3: leading junk
      reset_dut(0);
      stim_q.delete();
      stim_q.push_back(8'h00);
      stim_q.push_back(8'hFF);
      stim_q.push_back(8'h5A);
      push_fixed(8'h61);
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      check_writes(0, base, "c3");
      check_status(0, "c3");

      // Case 4: fixed image with random gaps, then random bad + good images with gaps
      reset_dut(0);
      stim_q.delete();
      push_fixed(8'h61);
      base = obs_size(0);
      drive_stream(0, 3);
      model_run(2, 32'h0);
      check_writes(0, base, "c4_gaps");
      check_status(0, "c4_gaps");
      reset_dut(0);
      stim_q.delete();
      push_random(2, 1'b0);
      push_random(2, 1'b1);
      base = obs_size(0);
      drive_stream(0, 3);
      model_run(2, 32'h0);
      check_writes(0, base, "c4_rand");
      check_status(0, "c4_rand");

      // Case 5: reset mid second word, then full reload
      reset_dut(0);
      stim_q.delete();
      push_fixed(8'h61);
      while (stim_q.size() > 6) void'(stim_q.pop_back());
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      reset_dut(0);
      repeat (3) @(negedge clk);
      check_writes(0, base, "c5_partial");
      check_status(0, "c5_partial");
      stim_q.delete();
      push_fixed(8'h61);
      base = obs_size(0);
      drive_stream(0, 0);
      model_run(2, 32'h0);
      check_writes(0, base, "c5_reload");
      check_status(0, "c5_reload");

      // Reset coincident with the word-completing transfer: no strobe
      reset_dut(0);
      base = obs_size(0);
      send_byte(0, 8'hA5, 0);
      send_byte(0, 8'h93, 0);
      send_byte(0, 8'h00, 0);
      send_byte(0, 8'h50, 0);
      @(negedge clk);
      set_in(0, 1'b1, 8'h00);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      set_in(0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check("rst_on_word_nwrites", 64'(obs_size(0) - base), 64'd0);
      check("rst_on_word_cpu_reset_n", {63'd0, if_a.cpu_reset_n}, 64'd0);
      check("rst_on_word_ready", {63'd0, if_a.byte_ready}, 64'd1);

      // Case 6: eight-word image at 0x100, one byte per cycle
      stim_q.delete();
      push_random(8, 1'b1);
      base = obs_size(1);
      drive_stream(1, 0);
      model_run(8, 32'h100);
      check_writes(1, base, "c6");
      check_status(1, "c6");
      for (int k = 0; k < 8; k++) begin
         check($sformatf("c6_addr%0d", k), {32'd0, get_obs(1, base + k)[63:32]},
               64'(32'h100 + 32'(k * 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fw_loader.md
Name: fw_loader

Overview:
- Writer side of the instruction-memory interface: receives a firmware image as a byte stream and writes it, word by word, into the instruction store that the program counter reads.
- Holds the CPU in reset until a complete image with a valid checksum has been written, then releases it.
- Sits between the external byte source (UART or bench) and the write port of the instruction memory / CPU reset input.

Parameters:
- CPU_WIDTH, 32, instruction/data word width in bits; must be a multiple of 8.
- FW_LENGTH, 8, number of instruction words in the image; must be >= 1.
- CMD_WIDTH, 32'h4, byte-address increment between consecutive words.
- START_ADDRESS, 32'h0, byte address of the first word written.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- s_reset  input  1  synchronous, active-high reset.
- byte_valid  input  1  byte_data holds a valid byte this cycle.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle. A transfer happens when byte_valid && byte_ready.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_address  output  CPU_WIDTH  byte address of the word being written.
- mem_data  output  CPU_WIDTH  assembled instruction word.
- cpu_reset_n  output  1  active-low CPU reset; high only in DONE.
- load_done  output  1  image loaded and checksum OK.
- load_error  output  1  checksum mismatch on the last attempt.

Behaviour:
- Clock and reset: one clock, clk; s_reset is synchronous and active-high.
- State on reset: IDLE; all outputs 0 except byte_ready=1; word and byte counters, shift register and checksum accumulator cleared.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- Transfers: only a cycle with byte_valid && byte_ready is a transfer. byte_valid without byte_ready is ignored, and the byte must be held by the source.
- IDLE:
  - byte_ready=1.
  - Transfer of 0xA5 -> LOAD with counters and checksum cleared.
  - Any other byte is consumed and discarded.
- LOAD:
  - byte_ready=1.
  - Each transfer shifts the byte into the word little-endian: first byte is bits [7:0].
  - Each transfer XORs the byte into the 8-bit checksum.
  - On the transfer completing a word (byte index CPU_WIDTH/8-1), the next cycle registers mem_we=1 for exactly one cycle, with:
    - mem_data = the assembled word;
    - mem_address = START_ADDRESS + word_index*CMD_WIDTH (CPU_WIDTH-bit wrap-around arithmetic).
  - Back-to-back transfers every cycle are supported with no stall; byte_ready never drops in LOAD.
  - After the transfer completing word FW_LENGTH-1 -> CHECK. The final mem_we pulse occurs in the first CHECK cycle.
- CHECK:
  - byte_ready=1.
  - The next transfer is compared with the accumulated XOR.
  - Equal -> DONE. Not equal -> ERROR.
- DONE:
  - byte_ready=0, load_done=1, cpu_reset_n=1.
  - Terminal until s_reset.
- ERROR:
  - byte_ready=1, load_error=1, cpu_reset_n=0.
  - Transfer of 0xA5 -> LOAD: clears load_error, counters and checksum; the old memory contents are overwritten.
  - Other bytes are discarded.
- cpu_reset_n: 0 in every state except DONE, registered.
- mem_address/mem_data: hold their last values between strobes. Only mem_we qualifies them.
- Reset mid-operation: s_reset at any point, including the mem_we cycle, -> IDLE next edge. mem_we=0 on that edge (no write). Partial word and checksum are discarded.
- s_reset has priority over any simultaneous transfer.

Test Plan:
- FW_LENGTH=2, stream A5 93 00 50 00 33 81 10 00 61 at one byte/cycle -> mem_we pulses twice: (addr 0x0, data 0x00500093) and (addr 0x4, data 0x00108133). Then load_done=1, cpu_reset_n=1, byte_ready=0.
- Same image with checksum byte 0x62 -> load_error=1, cpu_reset_n=0, load_done=0. Then resend the full correct stream -> DONE, with the memory rewritten at 0x0/0x4.
- Leading junk 00 FF 5A before A5 -> junk ignored (no mem_we). The load then completes as in case 1.
- byte_valid toggled randomly with gaps, plus byte_data changed while byte_valid=0 -> identical writes and result to case 1.
- s_reset asserted after the 6th byte (mid second word) -> no further mem_we, state IDLE, cpu_reset_n=0. A subsequent full stream loads correctly from address 0x0.
- START_ADDRESS=0x100, FW_LENGTH=8, 32 data bytes at one byte/cycle -> 8 strobes at 0x100..0x11C in steps of 4, with no missed or duplicated strobes.
